// File: rtl/spy_chain_sample_ctrl.sv
// Delay-chain sensor sequencer: launches alternating edges, samples wait_cycles+1 clocks later, counts mismatches.
// Each trial costs wait_cycles+3 clocks; counts held in REPORT until result_ready, start ignored while busy.
module spy_chain_sample_ctrl #(
  parameter int CNT_W     = 16,
  parameter int WAIT_W    = 8,
  parameter bit INVERTING = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_trials,
  input  logic [WAIT_W-1:0] wait_cycles,
  output logic              busy,
  output logic              chain_in,
  input  logic              chain_out,
  output logic              result_valid,
  input  logic              result_ready,
  output logic [CNT_W-1:0]  trial_count,
  output logic [CNT_W-1:0]  fail_rise,
  output logic [CNT_W-1:0]  fail_fall
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_CHECK,
    S_REPORT
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  trialsLatched;
  logic [WAIT_W-1:0] waitLatched;
  logic [WAIT_W-1:0] waitCnt;
  logic              expectedBit;

  // Deliberately unsynchronised: a late chain edge shows up here as a wrong or metastable sample.
  (* keep = 1 *) logic captureFlop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      chain_in      <= 1'b0;
      busy          <= 1'b0;
      result_valid  <= 1'b0;
      trial_count   <= '0;
      fail_rise     <= '0;
      fail_fall     <= '0;
      captureFlop   <= 1'b0;
      trialsLatched <= '0;
      waitLatched   <= '0;
      waitCnt       <= '0;
      expectedBit   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            trial_count <= '0;
            fail_rise   <= '0;
            fail_fall   <= '0;
            busy        <= 1'b1;
            if (num_trials != '0) begin
              trialsLatched <= num_trials;
              waitLatched   <= wait_cycles;
              state         <= S_LAUNCH;
            end else begin
              result_valid <= 1'b1;
              state        <= S_REPORT;
            end
          end
        end

        S_LAUNCH: begin
          chain_in    <= ~chain_in;
          expectedBit <= ~chain_in ^ INVERTING;
          waitCnt     <= waitLatched;
          state       <= S_WAIT;
        end

        S_WAIT: begin
          if (waitCnt == '0) begin
            captureFlop <= chain_out;
            state       <= S_CHECK;
          end else begin
            waitCnt <= waitCnt - 1'b1;
          end
        end

        S_CHECK: begin
          trial_count <= trial_count + 1'b1;
          if (captureFlop != expectedBit) begin
            if (chain_in) fail_rise <= fail_rise + 1'b1;
            else          fail_fall <= fail_fall + 1'b1;
          end
          if (trial_count + 1'b1 == trialsLatched) begin
            result_valid <= 1'b1;
            state        <= S_REPORT;
          end else begin
            state <= S_LAUNCH;
          end
        end

        S_REPORT: begin
          if (result_ready) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spy_chain_sample_ctrl.sv
// Bench for spy_chain_sample_ctrl: two instances (INVERTING=0/1) share stimulus, each drives its own chain model.
module tb_spy_chain_sample_ctrl;
  localparam int CW = 16;
  localparam int WW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          result_ready = 1'b0;
  logic [CW-1:0] num_trials = '0;
  logic [WW-1:0] wait_cycles = '0;

  logic [1:0]    busyV, chainIn, chainOut, resValid;
  logic [CW-1:0] trialCnt [2];
  logic [CW-1:0] failRise [2];
  logic [CW-1:0] failFall [2];

  spy_chain_sample_ctrl #(.CNT_W(CW), .WAIT_W(WW), .INVERTING(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_trials(num_trials), .wait_cycles(wait_cycles),
    .busy(busyV[0]), .chain_in(chainIn[0]), .chain_out(chainOut[0]), .result_valid(resValid[0]),
    .result_ready(result_ready), .trial_count(trialCnt[0]), .fail_rise(failRise[0]), .fail_fall(failFall[0])
  );

  spy_chain_sample_ctrl #(.CNT_W(CW), .WAIT_W(WW), .INVERTING(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_trials(num_trials), .wait_cycles(wait_cycles),
    .busy(busyV[1]), .chain_in(chainIn[1]), .chain_out(chainOut[1]), .result_valid(resValid[1]),
    .result_ready(result_ready), .trial_count(trialCnt[1]), .fail_rise(failRise[1]), .fail_fall(failFall[1])
  );

  // Chain model: chainDepth register stages (0 = plain wire), optionally inverted.
  int         chainDepth = 0;
  logic       physInv = 1'b0;
  logic [15:0] pipe0 = '0;
  logic [15:0] pipe1 = '0;
  always @(posedge clk) begin
    pipe0 <= {pipe0[14:0], chainIn[0]};
    pipe1 <= {pipe1[14:0], chainIn[1]};
  end
  assign chainOut[0] = ((chainDepth == 0) ? chainIn[0] : pipe0[chainDepth-1]) ^ physInv;
  assign chainOut[1] = ((chainDepth == 0) ? chainIn[1] : pipe1[chainDepth-1]) ^ physInv;

  int vectors = 0;
  int miscompares = 0;
  bit modelLevel = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch k (1-based) drives level c0^(k odd); its sample sees the chain input as it was
  // (wait - depth) clocks after the launch edge, with launches spaced wait+3 apart.
  function automatic void predict(input int n, input int w, input int d, input bit pinv,
                                  input bit c0, input bit inv, output int rise, output int fall);
    int  t;
    bit  lk;
    bit  seen;
    rise = 0;
    fall = 0;
    for (int k = 1; k <= n; k++) begin
      lk = c0 ^ bit'(k % 2);
      t  = (k - 1) * (w + 3) + w - d;
      if (t < 0) seen = c0;
      else       seen = c0 ^ bit'((t / (w + 3) + 1) % 2);
      if ((seen ^ pinv) != (lk ^ inv)) begin
        if (lk) rise++;
        else    fall++;
      end
    end
  endfunction

  task automatic runMeas(input int n, input int w, input int d, input bit pinv, input int hold,
                         input int expTrial, input int r0, input int f0, input int r1, input int f1);
    int  cycles;
    int  er [2];
    int  ef [2];
    bit  endLevel;
    er[0] = r0; ef[0] = f0; er[1] = r1; ef[1] = f1;
    endLevel = modelLevel ^ bit'(n % 2);
    chainDepth = d;
    physInv = pinv;
    repeat (10) tick();
    num_trials = CW'(n);
    wait_cycles = WW'(w);
    start = 1'b1;
    tick();
    start = 1'b0;
    num_trials = CW'($urandom_range(1, 9));
    wait_cycles = WW'($urandom_range(0, 9));
    cycles = 0;
    while (resValid[0] !== 1'b1 && cycles < n * (w + 3) + 20) begin
      tick();
      cycles++;
    end
    check($sformatf("latency n=%0d w=%0d", n, w), cycles, n * (w + 3));
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d valid", i), int'(resValid[i]), 1);
      check($sformatf("dut%0d busy", i), int'(busyV[i]), 1);
      check($sformatf("dut%0d trials", i), int'(trialCnt[i]), expTrial);
      check($sformatf("dut%0d fail_rise", i), int'(failRise[i]), er[i]);
      check($sformatf("dut%0d fail_fall", i), int'(failFall[i]), ef[i]);
      check($sformatf("dut%0d chain_in", i), int'(chainIn[i]), int'(endLevel));
    end
    for (int c = 0; c < hold; c++) begin
      start = 1'b1;
      num_trials = CW'(5);
      tick();
      for (int i = 0; i < 2; i++) begin
        check($sformatf("hold%0d dut%0d valid", c, i), int'(resValid[i]), 1);
        check($sformatf("hold%0d dut%0d busy", c, i), int'(busyV[i]), 1);
        check($sformatf("hold%0d dut%0d trials", c, i), int'(trialCnt[i]), expTrial);
        check($sformatf("hold%0d dut%0d rise", c, i), int'(failRise[i]), er[i]);
        check($sformatf("hold%0d dut%0d fall", c, i), int'(failFall[i]), ef[i]);
        check($sformatf("hold%0d dut%0d chain_in", c, i), int'(chainIn[i]), int'(endLevel));
      end
    end
    start = 1'b0;
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("dut%0d valid drop", i), int'(resValid[i]), 0);
      check($sformatf("dut%0d busy drop", i), int'(busyV[i]), 0);
    end
    modelLevel = endLevel;
  endtask

  typedef struct {
    int n; int w; int d; bit pinv; int hold;
    int trial; int r0; int f0; int r1; int f1;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int n, w, d, r0, f0, r1, f1, skip;
    bit p;
    //            n  w    d  pinv hold trial r0 f0 r1 f1
    tbl[0] = '{2, 0,   0, 1'b1, 0,  2,    1, 1, 0, 0};
    tbl[1] = '{4, 2,   0, 1'b0, 0,  4,    0, 0, 2, 2};
    tbl[2] = '{6, 3,   5, 1'b0, 0,  6,    3, 3, 0, 0};
    tbl[3] = '{6, 5,   5, 1'b0, 0,  6,    0, 0, 3, 3};
    tbl[4] = '{0, 7,   0, 1'b0, 0,  0,    0, 0, 0, 0};
    tbl[5] = '{3, 1,   0, 1'b0, 10, 3,    0, 0, 2, 1};
    tbl[6] = '{1, 255, 5, 1'b0, 0,  1,    0, 0, 0, 1};

    tick();
    tick();
    for (int i = 0; i < 2; i++) begin
      check($sformatf("reset dut%0d busy", i), int'(busyV[i]), 0);
      check($sformatf("reset dut%0d valid", i), int'(resValid[i]), 0);
      check($sformatf("reset dut%0d chain_in", i), int'(chainIn[i]), 0);
      check($sformatf("reset dut%0d trials", i), int'(trialCnt[i]), 0);
      check($sformatf("reset dut%0d rise", i), int'(failRise[i]), 0);
      check($sformatf("reset dut%0d fall", i), int'(failFall[i]), 0);
    end
    rst_n = 1'b1;
    modelLevel = 1'b0;

    for (int v = 0; v < 7; v++)
      runMeas(tbl[v].n, tbl[v].w, tbl[v].d, tbl[v].pinv, tbl[v].hold,
              tbl[v].trial, tbl[v].r0, tbl[v].f0, tbl[v].r1, tbl[v].f1);

    for (int r = 0; r < 10; r++) begin
      n = $urandom_range(1, 6);
      w = $urandom_range(0, 6);
      d = $urandom_range(0, 6);
      p = 1'($urandom_range(0, 1));
      predict(n, w, d, p, modelLevel, 1'b0, r0, f0);
      predict(n, w, d, p, modelLevel, 1'b1, r1, f1);
      runMeas(n, w, d, p, 0, n, r0, f0, r1, f1);
    end

    // Reset while in WAIT with chain_in driven high.
    chainDepth = 0;
    physInv = 1'b0;
    repeat (10) tick();
    num_trials = CW'(3);
    wait_cycles = WW'(10);
    start = 1'b1;
    tick();
    start = 1'b0;
    skip = (modelLevel == 1'b0) ? 3 : 3 + 13;
    repeat (skip) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("midreset dut%0d busy", i), int'(busyV[i]), 0);
      check($sformatf("midreset dut%0d valid", i), int'(resValid[i]), 0);
      check($sformatf("midreset dut%0d chain_in", i), int'(chainIn[i]), 0);
      check($sformatf("midreset dut%0d trials", i), int'(trialCnt[i]), 0);
    end
    modelLevel = 1'b0;
    runMeas(4, 2, 0, 1'b0, 0, 4, 0, 0, 2, 2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation exceeded time limit, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog");
  end

endmodule
